// File: rtl/ntt_twiddle_scheduler.sv
// ntt_twiddle_scheduler: builds omega^k mod m twiddle table iteratively, then streams radix-2 NTT butterflies over valid/ready.
module ntt_twiddle_scheduler #(
  parameter int WIDTH = 8,
  parameter int N     = 8,
  parameter int LOGN  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] omega,
  input  logic [WIDTH-1:0] mod,
  output logic             busy,
  output logic             done,
  output logic             bf_valid,
  input  logic             bf_ready,
  output logic [LOGN-1:0]  bf_idx_a,
  output logic [LOGN-1:0]  bf_idx_b,
  output logic [WIDTH-1:0] bf_twiddle
);
  typedef enum logic [1:0] {IDLE, GEN, SCHED, DONE} state_t;
  localparam logic [LOGN-1:0] SMAX = LOGN'(LOGN - 1);
  localparam logic [LOGN-1:0] KMAX = LOGN'(N - 1);
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_omega, r_mod, r_tw;
  logic [WIDTH-1:0] r_tab [N];
  logic [LOGN-1:0] r_k, r_s, r_g, r_j, r_a, r_b;
  logic r_busy, r_done, r_valid;
  logic w_go, w_hs, w_jlast, w_gend, w_last;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_red, w_ntw;
  logic [LOGN:0] w_half, w_gn;
  logic [LOGN-1:0] w_ns, w_ng, w_nj, w_na, w_nb, w_nhalf;
  assign busy       = r_busy;
  assign done       = r_done;
  assign bf_valid   = r_valid;
  assign bf_idx_a   = r_a;
  assign bf_idx_b   = r_b;
  assign bf_twiddle = r_tw;
  assign w_go = (r_state == IDLE) && start && (mod != '0);
  assign w_hs = r_valid && bf_ready;
  // k == 0 seeds the table with 1 so the same reduction gives 1 % mod
  assign w_prod = (r_k == '0) ? (2*WIDTH)'(1)
                : {{WIDTH{1'b0}}, r_tab[r_k - LOGN'(1)]} * {{WIDTH{1'b0}}, r_omega};
  assign w_red = WIDTH'(w_prod % {{WIDTH{1'b0}}, r_mod});
  // Successor of the current (stage, group, j) in loop order
  assign w_half  = (LOGN+1)'(1) << r_s;
  assign w_gn    = {1'b0, r_g} + (w_half << 1);
  assign w_jlast = ({1'b0, r_j} == w_half - 1'b1);
  assign w_gend  = w_gn[LOGN];
  assign w_last  = w_jlast && w_gend && (r_s == SMAX);
  assign w_ns    = (w_jlast && w_gend) ? r_s + 1'b1 : r_s;
  assign w_ng    = w_jlast ? (w_gend ? '0 : w_gn[LOGN-1:0]) : r_g;
  assign w_nj    = w_jlast ? '0 : r_j + 1'b1;
  assign w_nhalf = LOGN'(1) << w_ns;
  assign w_na    = w_ng + w_nj;
  assign w_nb    = w_na + w_nhalf;
  assign w_ntw   = r_tab[w_nj << (SMAX - w_ns)];
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_go ? GEN : IDLE;
      GEN:     w_next = (r_k == KMAX) ? SCHED : GEN;
      SCHED:   w_next = (w_hs && w_last) ? DONE : SCHED;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_omega <= '0;
      r_mod   <= '0;
      r_k     <= '0;
      r_s     <= '0;
      r_g     <= '0;
      r_j     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_tw    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      for (int i = 0; i < N; i++) r_tab[i] <= '0;
    end else begin
      if (w_go) begin
        r_omega <= omega;
        r_mod   <= mod;
        r_k     <= '0;
        r_s     <= '0;
        r_g     <= '0;
        r_j     <= '0;
        r_busy  <= 1'b1;
      end
      if (r_state == GEN) begin
        r_tab[r_k] <= w_red;
        r_k        <= r_k + 1'b1;
        if (r_k == KMAX) begin
          r_valid <= 1'b1;
          r_a     <= '0;
          r_b     <= LOGN'(1);
          r_tw    <= r_tab[0];
        end
      end
      if (r_state == SCHED && w_hs) begin
        if (w_last) begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_s  <= w_ns;
          r_g  <= w_ng;
          r_j  <= w_nj;
          r_a  <= w_na;
          r_b  <= w_nb;
          r_tw <= w_ntw;
        end
      end
      if (r_state == DONE) r_done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ntt_twiddle_scheduler.sv
// tb_ntt_twiddle_scheduler: scoreboard bench for the 8-point NTT twiddle scheduler.
module tb_ntt_twiddle_scheduler;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, bf_ready = 1'b1;
  logic [7:0] omega = '0, mod = '0;
  logic busy, done, bf_valid;
  logic [2:0] bf_idx_a, bf_idx_b;
  logic [7:0] bf_twiddle;
  typedef struct packed {logic [2:0] a; logic [2:0] b; logic [7:0] tw;} desc_t;
  desc_t exp_q[$], obs_q[$];
  int hs_rel[$];
  int n_assert = 0, n_fail = 0;
  int done_rel, done_cnt, overlap, hold_bad;
  logic busy1;
  always #5 clk = ~clk;
  ntt_twiddle_scheduler #(.WIDTH(8), .N(8), .LOGN(3)) dut (
    .clk(clk), .rst(rst), .start(start), .omega(omega), .mod(mod),
    .busy(busy), .done(done), .bf_valid(bf_valid), .bf_ready(bf_ready),
    .bf_idx_a(bf_idx_a), .bf_idx_b(bf_idx_b), .bf_twiddle(bf_twiddle)
  );
  task automatic build_expected(input int om, input int md);
    int t[8];
    t[0] = 1 % md;
    for (int k = 1; k < 8; k++) t[k] = (t[k-1] * om) % md;
    for (int s = 0; s < 3; s++)
      for (int g = 0; g < 8; g += 2 << s)
        for (int j = 0; j < (1 << s); j++)
          exp_q.push_back(desc_t'{3'(g + j), 3'(g + j + (1 << s)), 8'(t[j << (2 - s)])});
  endtask
  // Drives one start and records everything the DUT emits for budget cycles
  task automatic run_stream(input logic [7:0] om, input logic [7:0] md, input int stall_at,
                            input int stall_len, input int p1, input int p2, input int budget);
    int nhs, stalled;
    logic stall;
    desc_t held;
    obs_q.delete(); hs_rel.delete();
    done_rel = -1; done_cnt = 0; overlap = 0; hold_bad = 0; nhs = 0; stalled = 0; held = '0;
    @(negedge clk);
    omega = om; mod = md; start = 1'b1; bf_ready = 1'b1;
    for (int rel = 1; rel <= budget; rel++) begin
      @(negedge clk);
      start = (rel == p1) || (rel == p2);
      omega = start ? 8'd3 : om;
      if (rel == 1) busy1 = busy;
      if (done) begin
        done_cnt++;
        if (done_rel < 0) done_rel = rel;
      end
      if (done && bf_valid) overlap++;
      stall = bf_valid && (nhs == stall_at) && (stalled < stall_len);
      if (stall) begin
        if (stalled == 0) held = {bf_idx_a, bf_idx_b, bf_twiddle};
        else if ({bf_idx_a, bf_idx_b, bf_twiddle} != held) hold_bad++;
        stalled++;
      end
      bf_ready = !stall;
      if (bf_valid && bf_ready) begin
        obs_q.push_back({bf_idx_a, bf_idx_b, bf_twiddle});
        hs_rel.push_back(rel);
        nhs++;
      end
    end
    start = 1'b0; bf_ready = 1'b1;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_assert++;
    if ({busy, done, bf_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy, done, bf_valid});
    end
    n_assert++;
    if ({bf_idx_a, bf_idx_b, bf_twiddle} !== 14'd0) begin
      n_fail++; $display("FAIL reset_desc: got %h expected 0", {bf_idx_a, bf_idx_b, bf_twiddle});
    end
    rst = 1'b0;
  endtask
  task automatic test_nominal;
    desc_t e, o;
    desc_t spot [4];
    int sidx [4];
    spot = '{desc_t'{3'd0, 3'd1, 8'd1}, desc_t'{3'd0, 3'd2, 8'd1}, desc_t'{3'd1, 3'd3, 8'd4}, desc_t'{3'd3, 3'd7, 8'd8}};
    sidx = '{0, 4, 5, 11};
    exp_q.delete(); build_expected(2, 17);
    run_stream(8'd2, 8'd17, -1, 0, -1, -1, 28);
    n_assert++;
    if (obs_q.size() !== 12) begin n_fail++; $display("FAIL nominal_count: got %0d expected 12", obs_q.size()); end
    for (int i = 0; i < 4; i++) begin
      o = (sidx[i] < obs_q.size()) ? obs_q[sidx[i]] : '1;
      n_assert++;
      if (o !== spot[i]) begin
        n_fail++; $display("FAIL nominal_spot[%0d]: got %0d,%0d,%0d expected %0d,%0d,%0d", sidx[i], o.a, o.b, o.tw, spot[i].a, spot[i].b, spot[i].tw);
      end
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (i < obs_q.size()) ? obs_q[i] : '1;
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL nominal[%0d]: got %0d,%0d,%0d expected %0d,%0d,%0d", i, o.a, o.b, o.tw, e.a, e.b, e.tw); end
    end
    n_assert++;
    if (busy1 !== 1'b1) begin n_fail++; $display("FAIL nominal_busy: got %b expected 1", busy1); end
    n_assert++;
    if (hs_rel.size() == 0 || hs_rel[0] !== 9) begin n_fail++; $display("FAIL nominal_first_valid: got %0d expected 9", (hs_rel.size() > 0) ? hs_rel[0] : -1); end
    n_assert++;
    if (done_rel !== 21 || done_cnt !== 1) begin n_fail++; $display("FAIL nominal_done: got rel %0d cnt %0d expected rel 21 cnt 1", done_rel, done_cnt); end
    n_assert++;
    if (overlap !== 0) begin n_fail++; $display("FAIL nominal_overlap: got %0d expected 0", overlap); end
  endtask
  task automatic test_backpressure;
    desc_t e, o;
    exp_q.delete(); build_expected(2, 17);
    run_stream(8'd2, 8'd17, 4, 3, -1, -1, 30);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (i < obs_q.size()) ? obs_q[i] : '1;
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL bp[%0d]: got %0d,%0d,%0d expected %0d,%0d,%0d", i, o.a, o.b, o.tw, e.a, e.b, e.tw); end
    end
    n_assert++;
    if (obs_q.size() !== 12) begin n_fail++; $display("FAIL bp_count: got %0d expected 12", obs_q.size()); end
    n_assert++;
    if (hold_bad !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d changes expected 0", hold_bad); end
    n_assert++;
    if (hs_rel.size() < 5 || hs_rel[4] !== 16) begin n_fail++; $display("FAIL bp_fifth_hs: got %0d expected 16", (hs_rel.size() > 4) ? hs_rel[4] : -1); end
    n_assert++;
    if (done_rel !== 24) begin n_fail++; $display("FAIL bp_done: got %0d expected 24", done_rel); end
  endtask
  task automatic test_reduction;
    desc_t e, o;
    int nz;
    exp_q.delete(); build_expected(2, 17);
    run_stream(8'd19, 8'd17, -1, 0, -1, -1, 28);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (i < obs_q.size()) ? obs_q[i] : '1;
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL omega19[%0d]: got %0d,%0d,%0d expected %0d,%0d,%0d", i, o.a, o.b, o.tw, e.a, e.b, e.tw); end
    end
    run_stream(8'd5, 8'd1, -1, 0, -1, -1, 28);
    nz = 0;
    foreach (obs_q[i]) if (obs_q[i].tw !== 8'd0) nz++;
    n_assert++;
    if (obs_q.size() !== 12 || nz !== 0) begin n_fail++; $display("FAIL mod1: got %0d descs %0d nonzero tw expected 12 descs 0 nonzero", obs_q.size(), nz); end
  endtask
  task automatic test_ignored_start;
    desc_t e, o;
    run_stream(8'd2, 8'd0, -1, 0, -1, -1, 12);
    n_assert++;
    if (busy1 !== 1'b0 || obs_q.size() !== 0 || done_cnt !== 0) begin
      n_fail++; $display("FAIL mod0: got busy %b descs %0d done %0d expected 0 0 0", busy1, obs_q.size(), done_cnt);
    end
    exp_q.delete(); build_expected(2, 17);
    run_stream(8'd2, 8'd17, -1, 0, 3, 12, 28);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (i < obs_q.size()) ? obs_q[i] : '1;
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL repulse[%0d]: got %0d,%0d,%0d expected %0d,%0d,%0d", i, o.a, o.b, o.tw, e.a, e.b, e.tw); end
    end
    n_assert++;
    if (done_rel !== 21 || done_cnt !== 1 || obs_q.size() !== 12) begin
      n_fail++; $display("FAIL repulse_timing: got done %0d cnt %0d descs %0d expected 21 1 12", done_rel, done_cnt, obs_q.size());
    end
  endtask
  task automatic test_reset_mid;
    desc_t e, o;
    int nhs, bad;
    nhs = 0;
    @(negedge clk);
    omega = 8'd2; mod = 8'd17; start = 1'b1; bf_ready = 1'b1;
    for (int rel = 1; rel <= 30 && nhs < 6; rel++) begin
      @(negedge clk);
      start = 1'b0;
      if (bf_valid && bf_ready) nhs++;
    end
    n_assert++;
    if (nhs !== 6) begin n_fail++; $display("FAIL rstmid_reach: got %0d handshakes expected 6", nhs); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_assert++;
    if ({busy, done, bf_valid} !== 3'b000) begin n_fail++; $display("FAIL rstmid_flags: got %b expected 000", {busy, done, bf_valid}); end
    n_assert++;
    if ({bf_idx_a, bf_idx_b, bf_twiddle} !== 14'd0) begin n_fail++; $display("FAIL rstmid_desc: got %h expected 0", {bf_idx_a, bf_idx_b, bf_twiddle}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || bf_valid || busy) bad++;
    end
    n_assert++;
    if (bad !== 0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", bad); end
    exp_q.delete(); build_expected(2, 17);
    run_stream(8'd2, 8'd17, -1, 0, -1, -1, 28);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (i < obs_q.size()) ? obs_q[i] : '1;
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL rstmid_rerun[%0d]: got %0d,%0d,%0d expected %0d,%0d,%0d", i, o.a, o.b, o.tw, e.a, e.b, e.tw); end
    end
    n_assert++;
    if (done_rel !== 21) begin n_fail++; $display("FAIL rstmid_rerun_done: got %0d expected 21", done_rel); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset;
    test_nominal;
    test_backpressure;
    test_reduction;
    test_ignored_start;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
